// File: rtl/ddr4_mc_arb_pkg.sv
// Shared types and constants for the DDR4 MC port arbiter slice.
package ddr4_mc_arb_pkg;

    localparam int unsigned MC_CMD_WIDTH = 3;
    localparam int unsigned QOS_WIDTH    = 4;

    // Arbiter ownership state; encodings kept identical to the legacy values.
    typedef enum logic [0:0] {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    // Index width needed to address n_ports ports (at least 1 bit).
    function automatic int unsigned port_idx_width(input int unsigned n_ports);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n_ports) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr4_mc_rr_picker.sv
// Rotating-priority picker: first requester at or after rr_ptr wins.
module ddr4_mc_rr_picker
    import ddr4_mc_arb_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS = 4,
    parameter int unsigned C_IDX_WIDTH = 2
) (
    input  logic [C_NUM_PORTS-1:0] req,
    input  logic [C_IDX_WIDTH-1:0] rr_ptr,
    output logic [C_NUM_PORTS-1:0] gnt_oh,
    output logic [C_IDX_WIDTH-1:0] gnt_idx,
    output logic                   gnt_valid
);

    // Scan ports in rotated order starting at rr_ptr; take the first request.
    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < C_NUM_PORTS; k++) begin
            for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
                if (!found && req[p] &&
                    (((32'(rr_ptr) + k) % C_NUM_PORTS) == p)) begin
                    found     = 1'b1;
                    gnt_oh[p] = 1'b1;
                    gnt_idx   = C_IDX_WIDTH'(p);
                end
            end
        end
        gnt_valid = found;
    end

endmodule

// File: rtl/ddr4_mc_port_wrr_arbiter.sv
// Weighted round-robin arbiter sharing the MC app command channel between ports,
// with QoS boost, starvation escape and burst-long grant locking.
module ddr4_mc_port_wrr_arbiter
    import ddr4_mc_arb_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS        = 4,
    parameter int unsigned C_MC_ADDR_WIDTH    = 30,
    parameter int unsigned C_WEIGHT_WIDTH     = 4,
    parameter int unsigned C_STARVE_LIMIT     = 64,
    parameter int unsigned C_STARVE_CNT_WIDTH = 7
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [C_NUM_PORTS-1:0]                    req_en,
    input  logic [C_NUM_PORTS-1:0]                    req_last,
    input  logic [MC_CMD_WIDTH*C_NUM_PORTS-1:0]       req_cmd,
    input  logic [C_MC_ADDR_WIDTH*C_NUM_PORTS-1:0]    req_addr,
    input  logic [QOS_WIDTH*C_NUM_PORTS-1:0]          req_qos,
    input  logic [C_NUM_PORTS-1:0]                    req_autopre,
    output logic [C_NUM_PORTS-1:0]                    req_full,
    input  logic [C_WEIGHT_WIDTH*C_NUM_PORTS-1:0]     cfg_weight,
    output logic                                      mc_app_en,
    output logic [MC_CMD_WIDTH-1:0]                   mc_app_cmd,
    output logic [C_MC_ADDR_WIDTH-1:0]                mc_app_addr,
    output logic                                      mc_app_autoprecharge,
    input  logic                                      mc_app_rdy,
    output logic                                      grant_valid,
    output logic [port_idx_width(C_NUM_PORTS)-1:0]    grant_id
);

    localparam int unsigned NP  = C_NUM_PORTS;
    localparam int unsigned IDW = port_idx_width(C_NUM_PORTS);
    localparam int unsigned WW  = C_WEIGHT_WIDTH;
    localparam int unsigned SW  = C_STARVE_CNT_WIDTH;
    localparam logic [SW-1:0] STARVE_MAX = SW'(C_STARVE_LIMIT);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]  credit_q [NP];
    logic [WW-1:0]  credit_d [NP];
    logic [SW-1:0]  starve_q [NP];
    logic [SW-1:0]  starve_d [NP];

    logic           reload;
    logic [WW-1:0]  cred_eff [NP];
    logic [NP-1:0]  starved, cls_qos, cls_cred;
    logic [NP-1:0]  s_oh, q_oh, c_oh, win_oh;
    logic [IDW-1:0] s_idx, q_idx, c_idx, win_idx;
    logic           s_vld, q_vld, c_vld, win_valid;
    logic           own, grant_now, sel_en, sel_last, beat_accept;

    // Classify requesters; reload credits in the same cycle when every requester is dry.
    always_comb begin
        reload = (state_q == ARB) && (|req_en);
        for (int unsigned i = 0; i < NP; i++) begin
            starved[i] = req_en[i] && (starve_q[i] == STARVE_MAX);
            if (req_en[i] && ((credit_q[i] != '0) || starved[i])) begin
                reload = 1'b0;
            end
        end
        for (int unsigned i = 0; i < NP; i++) begin
            if (reload) begin
                cred_eff[i] = (cfg_weight[i*WW +: WW] == '0) ? WW'(1) : cfg_weight[i*WW +: WW];
            end else begin
                cred_eff[i] = credit_q[i];
            end
            cls_cred[i] = req_en[i] && (cred_eff[i] != '0);
            cls_qos[i]  = cls_cred[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] != '0);
        end
    end

    ddr4_mc_rr_picker #(.C_NUM_PORTS(NP), .C_IDX_WIDTH(IDW)) u_pick_starve (
        .req(starved), .rr_ptr(rr_ptr_q), .gnt_oh(s_oh), .gnt_idx(s_idx), .gnt_valid(s_vld)
    );
    ddr4_mc_rr_picker #(.C_NUM_PORTS(NP), .C_IDX_WIDTH(IDW)) u_pick_qos (
        .req(cls_qos), .rr_ptr(rr_ptr_q), .gnt_oh(q_oh), .gnt_idx(q_idx), .gnt_valid(q_vld)
    );
    ddr4_mc_rr_picker #(.C_NUM_PORTS(NP), .C_IDX_WIDTH(IDW)) u_pick_cred (
        .req(cls_cred), .rr_ptr(rr_ptr_q), .gnt_oh(c_oh), .gnt_idx(c_idx), .gnt_valid(c_vld)
    );

    // Highest non-empty priority class supplies the winner.
    always_comb begin
        win_valid = s_vld | q_vld | c_vld;
        if (s_vld) begin
            win_oh  = s_oh;
            win_idx = s_idx;
        end else if (q_vld) begin
            win_oh  = q_oh;
            win_idx = q_idx;
        end else begin
            win_oh  = c_oh;
            win_idx = c_idx;
        end
    end

    // Mux the owning port onto the MC channel and generate per-port backpressure.
    always_comb begin
        own                  = (state_q == OWN);
        sel_en               = 1'b0;
        sel_last             = 1'b0;
        mc_app_cmd           = '0;
        mc_app_addr          = '0;
        mc_app_autoprecharge = 1'b0;
        for (int unsigned i = 0; i < NP; i++) begin
            req_full[i] = !(own && (grant_id_q == IDW'(i)) && mc_app_rdy);
            if (own && (grant_id_q == IDW'(i))) begin
                sel_en               = req_en[i];
                sel_last             = req_last[i];
                mc_app_cmd           = req_cmd[i*MC_CMD_WIDTH +: MC_CMD_WIDTH];
                mc_app_addr          = req_addr[i*C_MC_ADDR_WIDTH +: C_MC_ADDR_WIDTH];
                mc_app_autoprecharge = req_autopre[i] & req_last[i];
            end
        end
        mc_app_en   = sel_en;
        beat_accept = sel_en & mc_app_rdy;
        grant_valid = own;
        grant_id    = grant_id_q;
    end

    // Next-state: grant in ARB, release after the accepted last beat, credit/starve upkeep.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        grant_now  = (state_q == ARB) && win_valid;
        case (state_q)
            ARB: begin
                if (win_valid) begin
                    state_d    = OWN;
                    grant_id_d = win_idx;
                    rr_ptr_d   = (win_idx == IDW'(NP - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            OWN: begin
                if (beat_accept && sel_last) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        for (int unsigned i = 0; i < NP; i++) begin
            credit_d[i] = cred_eff[i];
            if (grant_now && win_oh[i] && (cred_eff[i] != '0)) begin
                credit_d[i] = cred_eff[i] - 1'b1;
            end
            starve_d[i] = starve_q[i];
            if (!req_en[i] || (grant_now && win_oh[i])) begin
                starve_d[i] = '0;
            end else if (!(own && (grant_id_q == IDW'(i))) && (starve_q[i] != STARVE_MAX)) begin
                starve_d[i] = starve_q[i] + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned i = 0; i < NP; i++) begin
                credit_q[i] <= '0;
                starve_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int unsigned i = 0; i < NP; i++) begin
                credit_q[i] <= credit_d[i];
                starve_q[i] <= starve_d[i];
            end
        end
    end

endmodule
